// File: rtl/uart_link_checker_pkg.sv
// Shared definitions for the UART link checker: FSM encodings and
// helpers used to size the bit-period counters.
package uart_link_checker_pkg;

    // TX frame sequencer states
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_GAP
    } tx_state_t;

    // RX deframer states
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0 .. top-1 (at least one bit)
    function automatic int cnt_width(input int top);
        return (top < 2) ? 1 : $clog2(top);
    endfunction

endpackage

// File: rtl/uart_link_chk_fifo.sv
// Expected-byte FIFO. Pointers carry an extra wrap bit; full/empty are
// registered so that exp_ready never depends on same-cycle activity.
module uart_link_chk_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_nxt  = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, do_pop};
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer and flag registers; flags derived from the next pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                      (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

    // Storage write; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_link_checker.sv
// Host-side UART driver and checker for the CPU serial link.
// TX serialises accepted bytes onto serial_out; RX deframes serial_in and
// compares each byte with the head of the expected-byte FIFO.
// Optional even parity: define UART_LINK_CHK_PARITY_EN.
module uart_link_checker
    import uart_link_checker_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000,
    parameter int DATA_BITS  = 8,
    parameter int GAP_CYCLES = 0,
    parameter int EXP_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    input  logic                 serial_in,
    input  logic [DATA_BITS-1:0] exp_data,
    input  logic                 exp_valid,
    output logic                 exp_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_match,
    output logic                 frame_err,
    output logic                 exp_underflow,
    output logic [15:0]          pass_count,
    output logic [15:0]          fail_count
);
    localparam int SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_CYCLES   = SYMBOL_CYCLES / 2;
    localparam int CNT_W         = cnt_width(max_i(SYMBOL_CYCLES, GAP_CYCLES));
    localparam int BIT_W         = cnt_width(DATA_BITS);

    localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(SYMBOL_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // ---------------------------------------------------------------- TX
    tx_state_t            tx_state, tx_next;
    logic [CNT_W-1:0]     tx_cnt;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_tick;
`ifdef UART_LINK_CHK_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_tick = (tx_cnt == SYM_LAST);

    // TX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_next;
    end

    // TX next state: each bit lasts one symbol, gap only when configured
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_next = TX_START;
            TX_START:  if (tx_tick) tx_next = TX_DATA;
`ifdef UART_LINK_CHK_PARITY_EN
            TX_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_next = TX_PARITY;
            TX_PARITY: if (tx_tick) tx_next = TX_STOP;
`else
            TX_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_next = TX_STOP;
`endif
            TX_STOP:   if (tx_tick) tx_next = (GAP_CYCLES > 0) ? TX_GAP : TX_IDLE;
            TX_GAP:    if (tx_cnt == GAP_LAST) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: symbol counter, bit index, shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
`ifdef UART_LINK_CHK_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            if (tx_state == TX_IDLE || tx_next != tx_state ||
                (tx_state == TX_DATA && tx_tick))
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 1'b1;

            if (tx_state == TX_IDLE) begin
                tx_bit <= '0;
                if (tx_valid) begin
                    tx_shift <= tx_data;
`ifdef UART_LINK_CHK_PARITY_EN
                    tx_par   <= ^tx_data;
`endif
                end
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_bit   <= tx_bit + 1'b1;
                tx_shift <= tx_shift >> 1;
            end
        end
    end

    // TX outputs decoded from state; line idles high
    always_comb begin
        tx_ready   = 1'b0;
        serial_out = 1'b1;
        case (tx_state)
            TX_IDLE:   tx_ready   = 1'b1;
            TX_START:  serial_out = 1'b0;
            TX_DATA:   serial_out = tx_shift[0];
`ifdef UART_LINK_CHK_PARITY_EN
            TX_PARITY: serial_out = tx_par;
`endif
            default:   ;
        endcase
    end

    // ---------------------------------------------------------------- RX
    logic [1:0]           rx_sync;
    logic                 rx_s;
    rx_state_t            rx_state, rx_next;
    logic [CNT_W-1:0]     rx_cnt;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_tick, rx_half, rx_stop_smp;
    logic                 rx_done, rx_ferr;
`ifdef UART_LINK_CHK_PARITY_EN
    logic                 rx_perr;
`endif

    logic [DATA_BITS-1:0] exp_head;
    logic                 exp_full, exp_empty, exp_pop;

    assign rx_s        = rx_sync[1];
    assign rx_tick     = (rx_cnt == SYM_LAST);
    assign rx_half     = (rx_cnt == HALF_LAST);
    assign rx_stop_smp = (rx_state == RX_STOP) && rx_tick;

    // Two-flop synchroniser; idle-high so reset does not fake a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_sync <= 2'b11;
        else      rx_sync <= {rx_sync[0], serial_in};
    end

    // RX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_next;
    end

    // RX next state: mid-start check rejects glitches, then one sample per symbol
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (!rx_s) rx_next = RX_START;
            RX_START:  if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_LINK_CHK_PARITY_EN
            RX_DATA:   if (rx_tick && rx_bit == BIT_LAST) rx_next = RX_PARITY;
            RX_PARITY: if (rx_tick) rx_next = RX_STOP;
`else
            RX_DATA:   if (rx_tick && rx_bit == BIT_LAST) rx_next = RX_STOP;
`endif
            RX_STOP:   if (rx_tick) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: counter, LSB-first shift-in, frame result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data_q <= '0;
            rx_done   <= 1'b0;
            rx_ferr   <= 1'b0;
`ifdef UART_LINK_CHK_PARITY_EN
            rx_perr   <= 1'b0;
`endif
        end else begin
            if (rx_state == RX_IDLE || rx_next != rx_state ||
                (rx_state == RX_DATA && rx_tick))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;

            if (rx_state == RX_IDLE) rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_tick) begin
                rx_bit   <= rx_bit + 1'b1;
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            end

`ifdef UART_LINK_CHK_PARITY_EN
            if (rx_state == RX_START) rx_perr <= 1'b0;
            else if (rx_state == RX_PARITY && rx_tick) rx_perr <= rx_s ^ (^rx_shift);
`endif

            rx_done <= rx_stop_smp;
            if (rx_stop_smp) begin
                rx_data_q <= rx_shift;
`ifdef UART_LINK_CHK_PARITY_EN
                rx_ferr   <= !rx_s || rx_perr;
`else
                rx_ferr   <= !rx_s;
`endif
            end
        end
    end

    // Completion cycle: compare against the pre-push head and pop if present
    always_comb begin
        rx_valid = rx_done;
        exp_pop  = rx_done && !exp_empty;
        rx_match = rx_done && !exp_empty && !rx_ferr && (exp_head == rx_data_q);
    end

    assign rx_data   = rx_data_q;
    assign frame_err = rx_ferr;
    assign exp_ready = !exp_full;

    uart_link_chk_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (EXP_DEPTH)
    ) u_exp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (exp_valid),
        .push_data (exp_data),
        .pop       (exp_pop),
        .head      (exp_head),
        .full      (exp_full),
        .empty     (exp_empty)
    );

    // Saturating pass/fail counters and sticky underflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_count    <= '0;
            fail_count    <= '0;
            exp_underflow <= 1'b0;
        end else if (rx_done) begin
            if (rx_match) begin
                if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
            end else begin
                if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
            end
            if (exp_empty) exp_underflow <= 1'b1;
        end
    end

endmodule
